// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Shares one combinational instruction memory between a fetch port (f_*)
//   and a debug/loader read port (d_*). At most one port is granted per cycle.
//   The granted access is answered exactly one cycle later through a per-port
//   response register (rvalid pulse, rdata, err).
//
// Configuration macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin on contention, using last_gnt
//                   undefined -> fixed priority, fetch over debug
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   f_req/f_addr       fetch request and byte address
//   f_gnt              fetch grant (combinational, same cycle as f_req)
//   f_rvalid/f_rdata/f_err   fetch response, one cycle after f_gnt
//   f_flush            drops the fetch response that would appear next cycle
//   d_req/d_addr/d_gnt/d_rvalid/d_rdata/d_err   debug port, same rules, no flush
//   imem_addr/imem_rdata     combinational instruction-memory interface
//   dbg_last_gnt       observability of the last_gnt register (0=fetch,1=debug)
//
// Handshake: a port raises req with a stable addr and keeps both until it sees
// gnt high in the same cycle; the access is then committed at that clock edge
// and its response appears as a one-cycle rvalid pulse in the next cycle.
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int XLEN        = 32,
    parameter int ADDR_MASK_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_req,
    input  logic [XLEN-1:0] f_addr,
    output logic            f_gnt,
    output logic            f_rvalid,
    output logic [XLEN-1:0] f_rdata,
    output logic            f_err,
    input  logic            f_flush,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dbg_last_gnt
);

    logic            r_last_gnt;
    logic            r_f_rvalid;
    logic [XLEN-1:0] r_f_rdata;
    logic            r_f_err;
    logic            r_d_rvalid;
    logic [XLEN-1:0] r_d_rdata;
    logic            r_d_err;

    logic            w_f_win;
    logic            w_d_win;
    logic [XLEN-1:0] w_gnt_addr;
    logic            w_misaligned;
    logic [XLEN-1:0] w_rsp_data;

    // Arbitration. Grants are suppressed during reset so that an access
    // presented in the cycle rst rises is never committed.
    always_comb begin
        w_f_win = 1'b0;
        w_d_win = 1'b0;
        if (!rst) begin
`ifdef IMEM_ARB_RR_EN
            if (f_req && d_req) begin
                // last_gnt=1 means debug went last, so fetch is due.
                w_f_win = r_last_gnt;
                w_d_win = ~r_last_gnt;
            end else begin
                w_f_win = f_req;
                w_d_win = d_req;
            end
`else
            w_f_win = f_req;
            w_d_win = d_req & ~f_req;
`endif
        end
    end

    // With no grant the memory still sees f_addr, which keeps the mux a
    // single 2:1 select on the debug win.
    assign w_gnt_addr   = w_d_win ? d_addr : f_addr;
    assign w_misaligned = |w_gnt_addr[ADDR_MASK_W-1:0];
    assign w_rsp_data   = w_misaligned ? '0 : imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_f_err    <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            // A flushed fetch still consumed its slot; only the pulse is lost.
            r_f_rvalid <= w_f_win & ~f_flush;
            r_d_rvalid <= w_d_win;
            if (w_f_win) begin
                r_f_rdata  <= w_rsp_data;
                r_f_err    <= w_misaligned;
                r_last_gnt <= 1'b0;
            end
            if (w_d_win) begin
                r_d_rdata  <= w_rsp_data;
                r_d_err    <= w_misaligned;
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign f_gnt        = w_f_win;
    assign d_gnt        = w_d_win;
    assign imem_addr    = w_gnt_addr;
    assign f_rvalid     = r_f_rvalid;
    assign f_rdata      = r_f_rdata;
    assign f_err        = r_f_err;
    assign d_rvalid     = r_d_rvalid;
    assign d_rdata      = r_d_rdata;
    assign d_err        = r_d_err;
    assign dbg_last_gnt = r_last_gnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//   Directed scenarios followed by a randomized run, checked against a
//   reference model of the arbitration/response rules kept in this bench.
//   Inputs change 1 ns after the rising edge; combinational outputs are
//   checked 1 ns later and registered outputs right after each edge.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            f_req;
    logic [XLEN-1:0] f_addr;
    logic            f_gnt;
    logic            f_rvalid;
    logic [XLEN-1:0] f_rdata;
    logic            f_err;
    logic            f_flush;
    logic            d_req;
    logic [XLEN-1:0] d_addr;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            d_err;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            dbg_last_gnt;

    int n_checks;
    int n_pass;

    imem_arbiter #(.XLEN(XLEN), .ADDR_MASK_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_gnt        (f_gnt),
        .f_rvalid     (f_rvalid),
        .f_rdata      (f_rdata),
        .f_err        (f_err),
        .f_flush      (f_flush),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .dbg_last_gnt (dbg_last_gnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory contents ----------------
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        if (a == 32'h8) return 32'h00A0_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ---------------- comparison ----------------
    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req   = 1'b0;
        d_req   = 1'b0;
        f_flush = 1'b0;
        f_addr  = '0;
        d_addr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expected response for an access at address a.
    function automatic logic [XLEN-1:0] rsp_data(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) ? '0 : mem_word(a);
    endfunction

    function automatic logic [XLEN-1:0] rand_addr();
        logic [XLEN-1:0] a;
        a = XLEN'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // ---------------- reference model state ----------------
    bit              m_last;       // 0 = fetch granted last, 1 = debug
    bit              m_fw, m_dw;   // this cycle's expected winners
    bit              e_fv, e_dv;   // expected rvalid next cycle
    logic [XLEN-1:0] e_fd, e_dd;
    bit              e_fe, e_de;

    // Order expected when both ports request continuously from reset.
    function automatic bit expect_f_on_contention(input bit last);
`ifdef IMEM_ARB_RR_EN
        return last;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle_inputs();

        // ---- reset: grants forced low even with requests present ----
        f_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("gnt_f_in_reset", f_gnt, 0);
        check("gnt_d_in_reset", d_gnt, 0);
        step();
        step();
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_f_err", f_err, 0);
        check("rst_d_err", d_err, 0);
        check("rst_f_rdata", f_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_last_gnt", dbg_last_gnt, 1);
        idle_inputs();
        rst = 1'b0;

        // ---- single aligned fetch ----
        f_req  = 1'b1;
        f_addr = 32'h8;
        #1;
        check("fetch_gnt", f_gnt, 1);
        check("fetch_no_dgnt", d_gnt, 0);
        check("fetch_imem_addr", imem_addr, 32'h8);
        step();
        idle_inputs();
        check("fetch_rvalid", f_rvalid, 1);
        check("fetch_rdata", f_rdata, 32'h00A0_0093);
        check("fetch_err", f_err, 0);
        check("fetch_d_rvalid", d_rvalid, 0);
        step();
        check("fetch_pulse_end", f_rvalid, 0);

        // ---- contention from reset: 6 cycles ----
        do_reset();
        m_last = 1'b1;
        f_req  = 1'b1;
        d_req  = 1'b1;
        f_addr = 32'h0;
        d_addr = 32'h4;
        for (int c = 0; c < 6; c++) begin
            #1;
            m_fw = expect_f_on_contention(m_last);
            check($sformatf("cont_f_gnt_%0d", c), f_gnt, m_fw);
            check($sformatf("cont_d_gnt_%0d", c), d_gnt, !m_fw);
            check($sformatf("cont_addr_%0d", c), imem_addr, m_fw ? 32'h0 : 32'h4);
            m_last = !m_fw;
            @(posedge clk);
            #1;
            check($sformatf("cont_f_rv_%0d", c), f_rvalid, m_fw);
            check($sformatf("cont_d_rv_%0d", c), d_rvalid, !m_fw);
            if (m_fw) check($sformatf("cont_f_rd_%0d", c), f_rdata, mem_word(32'h0));
            else      check($sformatf("cont_d_rd_%0d", c), d_rdata, mem_word(32'h4));
        end
        idle_inputs();

        // ---- misaligned debug read ----
        d_req  = 1'b1;
        d_addr = 32'h6;
        #1;
        check("mis_d_gnt", d_gnt, 1);
        step();
        idle_inputs();
        check("mis_d_rvalid", d_rvalid, 1);
        check("mis_d_err", d_err, 1);
        check("mis_d_rdata", d_rdata, 0);
        check("mis_f_rvalid", f_rvalid, 0);

        // ---- flush of a granted fetch, then a clean fetch ----
        f_req   = 1'b1;
        f_addr  = 32'h10;
        f_flush = 1'b1;
        #1;
        check("flush_gnt", f_gnt, 1);
        step();
        check("flush_rvalid", f_rvalid, 0);
        f_addr  = 32'h14;
        f_flush = 1'b0;
        #1;
        check("after_flush_gnt", f_gnt, 1);
        step();
        idle_inputs();
        check("after_flush_rvalid", f_rvalid, 1);
        check("after_flush_rdata", f_rdata, mem_word(32'h14));
        // Flush with no fetch grant must not disturb a debug response.
        d_req   = 1'b1;
        d_addr  = 32'h20;
        f_flush = 1'b1;
        step();
        idle_inputs();
        check("idle_flush_d_rv", d_rvalid, 1);
        check("idle_flush_f_rv", f_rvalid, 0);

        // ---- reset raised on a granted fetch ----
        f_req  = 1'b1;
        f_addr = 32'h40;
        #1;
        check("pre_rst_gnt", f_gnt, 1);
        rst = 1'b1;
        #1;
        check("rst_kills_gnt", f_gnt, 0);
        step();
        check("rst_no_f_rvalid", f_rvalid, 0);
        check("rst_no_d_rvalid", d_rvalid, 0);
        check("rst_f_rdata_0", f_rdata, 0);
        check("rst_d_rdata_0", d_rdata, 0);
        check("rst_f_err_0", f_err, 0);
        check("rst_d_err_0", d_err, 0);
        d_req  = 1'b1;
        d_addr = 32'h44;
        rst    = 1'b0;
        #1;
        check("post_rst_f_gnt", f_gnt, 1);
        check("post_rst_d_gnt", d_gnt, 0);
        step();
        idle_inputs();
        check("post_rst_f_rv", f_rvalid, 1);

        // ---- randomized run against the model ----
        do_reset();
        m_last = 1'b1;
        e_fv = 1'b0; e_dv = 1'b0;
        e_fd = '0;   e_dd = '0;
        e_fe = 1'b0; e_de = 1'b0;
        m_fw = 1'b0; m_dw = 1'b0;
        for (int c = 0; c < 400; c++) begin
            check("rnd_f_rvalid", f_rvalid, e_fv);
            check("rnd_d_rvalid", d_rvalid, e_dv);
            if (e_fv) begin
                check("rnd_f_rdata", f_rdata, e_fd);
                check("rnd_f_err", f_err, e_fe);
            end
            if (e_dv) begin
                check("rnd_d_rdata", d_rdata, e_dd);
                check("rnd_d_err", d_err, e_de);
            end
            check("rnd_last_gnt", dbg_last_gnt, m_last);

            // A pending request stays up with its address until granted.
            if (!(f_req && !m_fw)) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = rand_addr();
            end
            if (!(d_req && !m_dw)) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = rand_addr();
            end
            f_flush = ($urandom_range(0, 3) == 0);
            #1;

            if (f_req && d_req) begin
                m_fw = expect_f_on_contention(m_last);
                m_dw = !m_fw;
            end else begin
                m_fw = f_req;
                m_dw = d_req;
            end
            check("rnd_f_gnt", f_gnt, m_fw);
            check("rnd_d_gnt", d_gnt, m_dw);
            check("rnd_imem_addr", imem_addr, m_dw ? d_addr : f_addr);

            e_fv = m_fw && !f_flush;
            e_dv = m_dw;
            if (m_fw) begin
                e_fd   = rsp_data(f_addr);
                e_fe   = (f_addr[1:0] != 2'b00);
                m_last = 1'b0;
            end
            if (m_dw) begin
                e_dd   = rsp_data(d_addr);
                e_de   = (d_addr[1:0] != 2'b00);
                m_last = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, address/data width.
REQ-002 Parameter: ADDR_MASK_W, 2, low address bits that must be zero for a word-aligned access.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 f_req  in  1  fetch-port request; held high with f_addr stable until f_gnt.
REQ-006 f_addr  in  XLEN  fetch-port byte address.
REQ-007 f_gnt  out  1  fetch-port grant; combinational, same cycle as the request.
REQ-008 f_rvalid  out  1  fetch response valid; one-cycle pulse.
REQ-009 f_rdata  out  XLEN  fetch response word.
REQ-010 f_err  out  1  fetch response misaligned-address flag; meaningful only with f_rvalid.
REQ-011 f_flush  in  1  discards any fetch response scheduled for the next cycle.
REQ-012 d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err  same widths and rules as the f_ ports  debug/loader read port; it has no flush input.
REQ-013 imem_addr  out  XLEN  address to the combinational instruction memory.
REQ-014 imem_rdata  in  XLEN  combinational instruction-memory read data.

Function
REQ-015 The block SHALL grant at most one port per cycle; f_gnt and d_gnt are never high together.
REQ-016 The block SHALL drive imem_addr to the granted port's address, or to f_addr when no port is granted.
REQ-017 A grant SHALL be issued in any cycle in which at least one request is high; there are no idle bubbles.
REQ-018 At the edge ending a granted cycle, the block SHALL register imem_rdata and the port ID into a response register.
REQ-019 The granted port's rvalid SHALL be high in the following cycle only, giving a fixed latency of 1 cycle from grant to response.
REQ-020 The port that was not granted SHALL keep its rvalid low during that response cycle.
REQ-021 The response register SHALL hold rdata stable until the next grant; rdata is undefined while rvalid is low.
REQ-022 If the granted address has any of bits [ADDR_MASK_W-1:0] set, the response SHALL carry err=1 and rdata=0; such a request is still granted and consumes its slot.
REQ-023 Back-to-back grants to the same port in consecutive cycles SHALL produce consecutive rvalid pulses, giving a throughput of 1 access per cycle.
REQ-024 If f_flush is high at an edge where a fetch grant is being registered, the next cycle's f_rvalid SHALL be 0. The debug-port schedule is unaffected.
REQ-025 If f_flush is high with no fetch grant that cycle, it SHALL have no effect.
REQ-026 The block SHALL keep a 1-bit register last_gnt (0 = fetch, 1 = debug), updated on every grant and used by the arbitration policy in REQ-031.

Reset
REQ-027 While rst is high at an edge, the block SHALL clear f_rvalid, d_rvalid, f_err and d_err to 0, clear both rdata registers to 0, and set last_gnt to 1 so that fetch wins first.
REQ-028 While rst is high, f_gnt and d_gnt SHALL be forced to 0 regardless of requests.
REQ-029 A grant issued in the cycle in which rst rises SHALL be discarded, with no rvalid afterwards.
REQ-030 The first grant after reset SHALL occur in the first cycle in which rst is low.

Configuration
REQ-031 Macro IMEM_ARB_RR_EN selects the arbitration policy.
- Defined: round-robin. On contention the grant goes to the port not equal to last_gnt; an uncontended request is always granted.
- Undefined: fixed priority, fetch over debug. last_gnt is still maintained but ignored, and debug may starve while f_req is held high.

Verification
REQ-032 Reset then f_req=1, f_addr=0x8, imem returning 0x00A00093 -> f_gnt=1 in the same cycle; next cycle f_rvalid=1, f_rdata=0x00A00093, f_err=0, d_rvalid=0.
REQ-033 Both ports request continuously for 6 cycles, f_addr=0x0, d_addr=0x4:
- With IMEM_ARB_RR_EN -> grant order F,D,F,D,F,D.
- Without it -> F on all 6 cycles and d_gnt never high.
REQ-034 d_req=1, d_addr=0x6 -> d_gnt=1; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-035 f_req granted at f_addr=0x10 with f_flush=1 in the same cycle -> next cycle f_rvalid=0; a grant at 0x14 in the following cycle with f_flush=0 -> f_rvalid=1 one cycle later.
REQ-036 rst raised in a cycle with f_gnt=1 -> no f_rvalid afterwards, all outputs 0. Release rst with both requesting -> fetch granted in the first cycle under both policies.
